load_select_scheduler: RTL and testbench
========================================

Name: load_select_scheduler

Overview:
- Sequences the load-switch FSM by driving its 2-bit DesiredLoad command.
- Arbitrates load-change requests from three sources by fixed priority: 0 = protection, 1 = manual, 2 = auto.
- After each command it waits for the switch outputs to reach the target pattern, then enforces a minimum dwell time.
- Forces the no-load (NUL) state on settle timeout and latches a fault.

Parameters:
- DWELL_CYCLES, 16: minimum clk cycles held in a settled load before another non-protection change is accepted.
- SETTLE_TIMEOUT, 32: maximum clk cycles allowed for sout_i to match the target pattern.
- CNT_W, 8: timer width; must satisfy 2^CNT_W > max(DWELL_CYCLES, SETTLE_TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  3  per-requester request; held high until granted.
- req_load  in  6  requested load per requester; bits [2i+1:2i] belong to requester i.
- req_grant  out  3  one-cycle, one-hot acceptance pulse.
- sout_i  in  6  switch outputs fed back from the FSM.
- fault_clr  in  1  clears a latched fault.
- desired_load  out  2  command to the FSM DesiredLoad input.
- busy  out  1  high in SETTLE and DWELL.
- fault  out  1  high in FAULT.

Behaviour:
- Load encodings: NUL = 00, LAA = 01, LBB = 10, LCC = 11.
- Target sout patterns: NUL = 000000, LAA = 110000, LBB = 001100, LCC = 000011.
- Reset (asynchronous):
  - state = IDLE, desired_load = NUL, timer = 0.
  - req_grant, busy and fault = 0.
  - Applies mid-operation too; any pending grant is dropped.
- Arbitration: the lowest-index asserted req_valid wins. Losers are not granted and must keep valid asserted.
- IDLE:
  - If the winner's load equals desired_load: pulse its grant; stay IDLE; desired_load unchanged (no-op ack).
  - Otherwise, registered on the same edge: desired_load <= winner load; pulse its grant; timer = 0; go SETTLE.
- SETTLE:
  - No grants.
  - timer increments each cycle.
  - If sout_i == target(desired_load): timer = 0; go DWELL. A match takes priority over timeout in the same cycle.
  - Else if timer == SETTLE_TIMEOUT-1: desired_load <= NUL; go FAULT.
- DWELL:
  - timer increments; at DWELL_CYCLES-1 go IDLE.
  - Requesters 1 and 2 are ignored.
  - Requester 0 preempts: it is processed exactly as in IDLE (grant, new command, SETTLE), or as a no-op ack if its load equals desired_load.
- FAULT:
  - fault = 1, desired_load = NUL, no grants.
  - Exit to IDLE only when fault_clr = 1 and sout_i == 000000 in the same cycle; fault_clr is ignored otherwise.
- Outputs:
  - busy is decoded from state; fault is registered.
  - Command latency: desired_load changes one clk after the winning req_valid is sampled.
- sout_i is sampled as-is; the FSM is synchronous to clk, so no synchronizer is used.

Decomposition:
- Shared package (fsm_pkg): load encodings NUL/LAA/LBB/LCC, the four 6-bit target patterns, and the scheduler state enum (IDLE, SETTLE, DWELL, FAULT). The FSM and its bench reuse the same constants.
- One natural sub-module: prio_arb3, a combinational fixed-priority picker that outputs a one-hot grant and the selected 2-bit load.
- Timer and state register stay in the top module.

Test Plan:
1. Reset then IDLE: hold rst=1 for 4 cycles with req_valid=010 (load LAA) → desired_load=00, grant=000. Release rst → grant=010 for one cycle, desired_load=01 the next cycle, busy=1. Drive sout_i=110000 → DWELL, then IDLE after 16 cycles.
2. Priority: req_valid=110, req_load=10_11_00, from IDLE → grant=010, desired_load=11. Requester 2 stays pending until the dwell ends, then grant=100 and desired_load=10.
3. Dwell preemption: in DWELL on LBB, assert req 0 with NUL → grant=001 next cycle, desired_load=00. A simultaneous req 1 gets no grant.
4. Settle timeout: command LCC and hold sout_i=000010 for 32 cycles → fault=1, desired_load=00. fault_clr with sout_i=000010 → stays FAULT. fault_clr with sout_i=000000 → IDLE, fault=0.
5. No-op: in IDLE with desired_load=01, request 1 asks for 01 → grant=010, desired_load stays 01, busy stays 0.
6. Reset mid-SETTLE: assert rst asynchronously (between edges) → desired_load=00, busy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared load encodings, switch target patterns and scheduler state type.
package fsm_pkg;

    localparam logic [1:0] LD_NUL = 2'b00;
    localparam logic [1:0] LD_LAA = 2'b01;
    localparam logic [1:0] LD_LBB = 2'b10;
    localparam logic [1:0] LD_LCC = 2'b11;

    localparam logic [5:0] PAT_NUL = 6'b000000;
    localparam logic [5:0] PAT_LAA = 6'b110000;
    localparam logic [5:0] PAT_LBB = 6'b001100;
    localparam logic [5:0] PAT_LCC = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_FAULT
    } sched_state_e;

    // Switch output pattern expected once the FSM has reached a load.
    function automatic logic [5:0] target_pattern(input logic [1:0] ld);
        logic [5:0] pat;
        case (ld)
            LD_LAA:  pat = PAT_LAA;
            LD_LBB:  pat = PAT_LBB;
            LD_LCC:  pat = PAT_LCC;
            default: pat = PAT_NUL;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/load_select_scheduler_prio_arb3.sv
// Fixed-priority picker over three load requesters; index 0 wins.
module prio_arb3 (
    input  logic [2:0] valid,
    input  logic [5:0] load,
    output logic [2:0] grant,
    output logic [1:0] load_sel,
    output logic       any
);

    // Lowest asserted index selects the one-hot grant and its load field.
    always_comb begin
        grant    = '0;
        load_sel = '0;
        any      = |valid;
        if (valid[0]) begin
            grant    = 3'b001;
            load_sel = load[1:0];
        end else if (valid[1]) begin
            grant    = 3'b010;
            load_sel = load[3:2];
        end else if (valid[2]) begin
            grant    = 3'b100;
            load_sel = load[5:4];
        end
    end

endmodule

// File: rtl/load_select_scheduler.sv
// Sequences the load-switch FSM: arbitrates requests, issues DesiredLoad,
// waits for the switch outputs to settle, enforces dwell, latches faults.
module load_select_scheduler
    import fsm_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 16,
    parameter int unsigned SETTLE_TIMEOUT = 32,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_valid,
    input  logic [5:0] req_load,
    output logic [2:0] req_grant,
    input  logic [5:0] sout_i,
    input  logic       fault_clr,
    output logic [1:0] desired_load,
    output logic       busy,
    output logic       fault
);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       dl_d;
    logic [2:0]       grant_d;
    logic [2:0]       arb_valid;
    logic [2:0]       arb_grant;
    logic [1:0]       arb_load;
    logic             arb_any;
    logic             settled;

    // Grant is registered, so a requester still shows valid during its grant
    // cycle; masking it here prevents a second ack of the same request.
    // In DWELL only the protection requester may compete.
    always_comb begin
        arb_valid = req_valid & ~req_grant;
        if (state_q == ST_DWELL) begin
            arb_valid = arb_valid & 3'b001;
        end
    end

    prio_arb3 u_arb (
        .valid    (arb_valid),
        .load     (req_load),
        .grant    (arb_grant),
        .load_sel (arb_load),
        .any      (arb_any)
    );

    assign settled = (sout_i == target_pattern(desired_load));
    assign busy    = (state_q == ST_SETTLE) || (state_q == ST_DWELL);

    // Next-state, timer, command and grant decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dl_d    = desired_load;
        grant_d = '0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (arb_any) begin
                    grant_d = arb_grant;
                    if (arb_load != desired_load) begin
                        dl_d    = arb_load;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                timer_d = timer_q + CNT_W'(1);
                if (settled) begin
                    timer_d = '0;
                    state_d = ST_DWELL;
                end else if (timer_q == CNT_W'(SETTLE_TIMEOUT - 1)) begin
                    timer_d = '0;
                    dl_d    = LD_NUL;
                    state_d = ST_FAULT;
                end
            end
            ST_DWELL: begin
                timer_d = timer_q + CNT_W'(1);
                if (arb_any && (arb_load != desired_load)) begin
                    grant_d = arb_grant;
                    dl_d    = arb_load;
                    timer_d = '0;
                    state_d = ST_SETTLE;
                end else begin
                    if (arb_any) begin
                        grant_d = arb_grant;
                    end
                    if (timer_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                timer_d = '0;
                dl_d    = LD_NUL;
                if (fault_clr && (sout_i == PAT_NUL)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                dl_d    = LD_NUL;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            desired_load <= LD_NUL;
            req_grant    <= '0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            desired_load <= dl_d;
            req_grant    <= grant_d;
            fault        <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_load_select_scheduler.sv
// Directed self-checking bench for load_select_scheduler.
module tb_load_select_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] req_valid;
    logic [5:0] req_load;
    logic [2:0] req_grant;
    logic [5:0] sout_i;
    logic       fault_clr;
    logic [1:0] desired_load;
    logic       busy;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] acc;

    load_select_scheduler #(
        .DWELL_CYCLES   (16),
        .SETTLE_TIMEOUT (32),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_load     (req_load),
        .req_grant    (req_grant),
        .sout_i       (sout_i),
        .fault_clr    (fault_clr),
        .desired_load (desired_load),
        .busy         (busy),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 3'b010;
        req_load  = 6'b00_01_00;
        sout_i    = 6'b000000;
        fault_clr = 1'b0;

        // 1. Reset held with a pending request, then release.
        steps(4);
        check("rst_dl", desired_load, 2'b00);
        check("rst_grant", req_grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fault, 1'b0);
        rst = 1'b0;
        step();
        check("t1_grant", req_grant, 3'b010);
        check("t1_dl", desired_load, 2'b01);
        check("t1_busy", busy, 1'b1);
        req_valid = 3'b000;
        step();
        check("t1_grant_pulse", req_grant, 3'b000);
        check("t1_settle_busy", busy, 1'b1);
        sout_i = 6'b110000;
        step();                          // match -> DWELL, timer 0
        steps(15);
        check("t1_dwell_busy", busy, 1'b1);
        step();
        check("t1_idle", busy, 1'b0);
        check("t1_idle_dl", desired_load, 2'b01);

        // 2. Priority: req1 beats req2; req2 waits out the dwell.
        req_valid = 3'b110;
        req_load  = 6'b10_11_00;
        step();
        check("t2_grant", req_grant, 3'b010);
        check("t2_dl", desired_load, 2'b11);
        req_valid = 3'b100;
        sout_i    = 6'b000011;
        step();                          // match -> DWELL
        check("t2_no_grant", req_grant, 3'b000);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            acc = acc | req_grant;
        end
        check("t2_dwell_blocks", acc, 3'b000);
        check("t2_idle", busy, 1'b0);
        step();
        check("t2_grant2", req_grant, 3'b100);
        check("t2_dl2", desired_load, 2'b10);
        req_valid = 3'b000;

        // 3. Protection preempts the dwell; req1 is held off.
        sout_i = 6'b001100;
        step();                          // -> DWELL on LBB
        steps(2);
        check("t3_in_dwell", busy, 1'b1);
        req_valid = 3'b011;
        req_load  = 6'b00_01_00;
        step();
        check("t3_grant", req_grant, 3'b001);
        check("t3_dl", desired_load, 2'b00);
        req_valid = 3'b010;
        sout_i    = 6'b000000;
        step();                          // -> DWELL on NUL
        check("t3_req1_blocked", req_grant, 3'b000);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            acc = acc | req_grant;
        end
        check("t3_dwell_blocks", acc, 3'b000);
        step();
        check("t3_req1_grant", req_grant, 3'b010);
        check("t3_req1_dl", desired_load, 2'b01);
        req_valid = 3'b000;
        sout_i    = 6'b110000;
        step();
        steps(16);
        check("t3_back_idle", busy, 1'b0);

        // 5. No-op ack in IDLE.
        req_valid = 3'b010;
        req_load  = 6'b00_01_00;
        step();
        check("t5_grant", req_grant, 3'b010);
        check("t5_dl", desired_load, 2'b01);
        check("t5_busy", busy, 1'b0);
        req_valid = 3'b000;
        step();
        check("t5_grant_pulse", req_grant, 3'b000);
        check("t5_busy2", busy, 1'b0);

        // 4. Settle timeout, fault, and fault clearing.
        req_valid = 3'b001;
        req_load  = 6'b00_00_11;
        step();
        check("t4_grant", req_grant, 3'b001);
        check("t4_dl", desired_load, 2'b11);
        req_valid = 3'b000;
        sout_i    = 6'b000010;
        steps(31);
        check("t4_pre_fault", fault, 1'b0);
        check("t4_pre_busy", busy, 1'b1);
        step();
        check("t4_fault", fault, 1'b1);
        check("t4_fault_dl", desired_load, 2'b00);
        check("t4_fault_busy", busy, 1'b0);
        fault_clr = 1'b1;
        step();
        check("t4_clr_blocked", fault, 1'b1);
        sout_i = 6'b000000;
        step();
        check("t4_cleared", fault, 1'b0);
        check("t4_cleared_busy", busy, 1'b0);
        check("t4_cleared_dl", desired_load, 2'b00);
        fault_clr = 1'b0;

        // 6. Asynchronous reset in the middle of SETTLE.
        req_valid = 3'b100;
        req_load  = 6'b01_00_00;
        step();
        check("t6_grant", req_grant, 3'b100);
        check("t6_dl", desired_load, 2'b01);
        req_valid = 3'b000;
        steps(3);
        check("t6_settling", busy, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_dl", desired_load, 2'b00);
        check("t6_async_busy", busy, 1'b0);
        check("t6_async_grant", req_grant, 3'b000);
        steps(2);
        rst = 1'b0;
        step();
        check("t6_post_dl", desired_load, 2'b00);
        check("t6_post_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
